// File: rtl/position_aggregator_if.sv
// Trade input, portfolio output and error flags of the position aggregator.
interface position_aggregator_if #(
  parameter int NUM_SLOTS = 8,
  parameter int QTY_W     = 16
);
  localparam int CNT_W = $clog2(NUM_SLOTS + 1);

  logic                             trade_valid;
  logic                             trade_ready;
  logic [QTY_W-1:0]                 trade_qty;
  logic [7:0]                       trade_maturity;
  logic                             trade_last;
  logic [NUM_SLOTS-1:0][QTY_W-1:0]  position;
  logic [NUM_SLOTS-1:0][7:0]        maturity;
  logic [CNT_W-1:0]                 slot_count;
  logic                             pos_valid;
  logic                             pos_ack;
  logic                             err_full;
  logic                             err_sat;
  logic                             err_illegal;

  modport master (
    output trade_valid, trade_qty, trade_maturity, trade_last, pos_ack,
    input  trade_ready, position, maturity, slot_count, pos_valid,
    input  err_full, err_sat, err_illegal
  );

  modport slave (
    input  trade_valid, trade_qty, trade_maturity, trade_last, pos_ack,
    output trade_ready, position, maturity, slot_count, pos_valid,
    output err_full, err_sat, err_illegal
  );
endinterface

// File: rtl/position_aggregator.sv
// Nets signed trades by contract maturity into position slots and
// holds the finished portfolio until the consumer acknowledges it.
module position_aggregator #(
  parameter int NUM_SLOTS = 8,
  parameter int QTY_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  position_aggregator_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_SLOTS);
  localparam int CNT_W = $clog2(NUM_SLOTS + 1);
  localparam logic [7:0] ILLEGAL = 8'hFF;

  typedef enum logic {ACCUM, HOLD} state_e;

  state_e                          state_q;
  logic [NUM_SLOTS-1:0][QTY_W-1:0] pos_q;
  logic [NUM_SLOTS-1:0][7:0]       mat_q;
  logic [CNT_W-1:0]                cnt_q;
  logic                            valid_q;
  logic                            full_q;
  logic                            sat_q;
  logic                            ill_q;

  logic                 hit;
  logic                 free;
  logic [IDX_W-1:0]     hit_idx;
  logic [IDX_W-1:0]     free_idx;
  logic signed [QTY_W:0] sum_d;
  logic [QTY_W-1:0]     acc_d;
  logic                 ovf_d;
  logic                 take;
  logic                 do_ill;
  logic                 do_acc;
  logic                 do_new;
  logic                 do_full;

  // A free slot is marked by the reserved maturity, so no separate
  // allocation bits are kept. Descending scan leaves the lowest index.
  always_comb begin
    hit      = 1'b0;
    free     = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (mat_q[i] != ILLEGAL && mat_q[i] == bus.trade_maturity) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (mat_q[i] == ILLEGAL) begin
        free     = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    sum_d = $signed({pos_q[hit_idx][QTY_W-1], pos_q[hit_idx]})
          + $signed({bus.trade_qty[QTY_W-1], bus.trade_qty});
    ovf_d = sum_d[QTY_W] ^ sum_d[QTY_W-1];
    acc_d = ovf_d ? {sum_d[QTY_W], {(QTY_W-1){~sum_d[QTY_W]}}}
                  : sum_d[QTY_W-1:0];
  end

  assign take    = (state_q == ACCUM) && bus.trade_valid;
  assign do_ill  = take && (bus.trade_maturity == ILLEGAL);
  assign do_acc  = take && !do_ill && hit;
  assign do_new  = take && !do_ill && !hit && free;
  assign do_full = take && !do_ill && !hit && !free;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ACCUM;
      pos_q   <= '0;
      mat_q   <= '1;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
      sat_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          unique case (1'b1)
            do_ill: ill_q <= 1'b1;
            do_acc: begin
              pos_q[hit_idx] <= acc_d;
              sat_q          <= sat_q | ovf_d;
            end
            do_new: begin
              pos_q[free_idx] <= bus.trade_qty;
              mat_q[free_idx] <= bus.trade_maturity;
              cnt_q           <= cnt_q + CNT_W'(1);
            end
            do_full: full_q <= 1'b1;
            default: ;
          endcase
          if (take && bus.trade_last) begin
            state_q <= HOLD;
            valid_q <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.pos_ack) begin
            state_q <= ACCUM;
            valid_q <= 1'b0;
            pos_q   <= '0;
            mat_q   <= '1;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            sat_q   <= 1'b0;
            ill_q   <= 1'b0;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign bus.trade_ready = (state_q == ACCUM);
  assign bus.position    = pos_q;
  assign bus.maturity    = mat_q;
  assign bus.slot_count  = cnt_q;
  assign bus.pos_valid   = valid_q;
  assign bus.err_full    = full_q;
  assign bus.err_sat     = sat_q;
  assign bus.err_illegal = ill_q;
endmodule
